// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit for the decode->execute path.
// Extends an immediate in one of five modes and carries it through STAGES valid/ready register stages.
module imm_ext_pipe #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        extop,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_illegal
);

    localparam int unsigned EXT_W = DATA_W - IMM_W;

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] stage_ill;
    logic [DATA_W-1:0] stage_data [STAGES];

    logic [DATA_W-1:0] z_ext;
    logic [DATA_W-1:0] s_ext;
    logic [DATA_W-1:0] ext_data;
    logic              ext_ill;

    // Extension result, computed in front of stage 0
    always_comb begin
        z_ext    = {{EXT_W{1'b0}}, imm};
        s_ext    = {{EXT_W{imm[IMM_W-1]}}, imm};
        ext_data = '0;
        ext_ill  = 1'b0;
        case (extop)
            3'd0:    ext_data = z_ext;
            3'd1:    ext_data = s_ext;
            3'd2:    ext_data = {imm, {EXT_W{1'b0}}};
            3'd3:    ext_data = s_ext << 2;
            3'd4:    ext_data = pc_plus4 + (s_ext << 2);
            default: ext_ill  = 1'b1;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              prev_valid;
        logic [DATA_W-1:0] prev_data;
        logic              prev_ill;
        logic              v_q;
        logic [DATA_W-1:0] d_q;
        logic              i_q;

        if (k == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = ext_data;
            assign prev_ill   = ext_ill;
        end else begin : g_body
            assign prev_valid = valid[k-1];
            assign prev_data  = stage_data[k-1];
            assign prev_ill   = stage_ill[k-1];
        end

        // Unrolled ready chain: a stage can move if any stage downstream has a bubble
        assign ready[k] = out_ready | ~(&valid[STAGES-1:k]);

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
                d_q <= '0;
                i_q <= 1'b0;
            end else begin
                if (flush) begin
                    v_q <= 1'b0;
                end else if (ready[k]) begin
                    v_q <= prev_valid;
                end
                if (ready[k] && prev_valid) begin
                    d_q <= prev_data;
                    i_q <= prev_ill;
                end
            end
        end

        assign valid[k]      = v_q;
        assign stage_data[k] = d_q;
        assign stage_ill[k]  = i_q;
    end

    assign in_ready    = ready[0];
    assign out_valid   = valid[STAGES-1];
    assign out_data    = stage_data[STAGES-1];
    assign out_illegal = stage_ill[STAGES-1];

endmodule
